// File: rtl/qdi_pkg.sv
// Shared types and constants for the QDI source arbiter: FSM states and
// e1of2 rail codes used on the R channel.
package qdi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NULL = 2'd2,
    ACK  = 2'd3
  } qdi_state_e;

  localparam logic [1:0] E1OF2_NULL = 2'b00;
  localparam logic [1:0] E1OF2_ZERO = 2'b01;
  localparam logic [1:0] E1OF2_ONE  = 2'b10;

  function automatic logic [1:0] e1of2_enc(input logic d);
    return d ? E1OF2_ONE : E1OF2_ZERO;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N, returned both one-hot and as a binary index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 valid,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt = '0;
    idx = '0;
    pos = '0;
    // Scan from the far end so the candidate closest to ptr is written last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr) + k) % N);
      if (req[pos]) idx = pos;
    end
    if (valid && (|req)) gnt = N'(1) << idx;
    else                 idx = '0;
  end

endmodule

// File: rtl/qdi_src_arbiter.sv
// Arbitrates N binary 4-phase requesters onto one e1of2 QDI data channel,
// handshaking with the asynchronous right enable through a flop synchronizer.
module qdi_src_arbiter
  import qdi_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         din,
  output logic [N-1:0]         ack,
  output logic [1:0]           R,
  input  logic                 Re,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 proto_err,
  inout  wire                  VDD,
  inout  wire                  GND
);

  localparam int IW = $clog2(N);

  logic unused_supply;
  assign unused_supply = VDD ^ GND;

  // Re synchronizer plus a parallel fill marker, so a grant after reset only
  // trusts Re_s once a real Re sample has reached the last stage.
  logic [SYNC_STAGES-1:0] re_sync_q, re_sync_d;
  logic [SYNC_STAGES-1:0] re_vld_q, re_vld_d;
  logic                   re_prev_q, re_prev_d;
  logic                   re_s, re_ok, re_rise;

  qdi_state_e    state_q, state_d;
  logic [1:0]    r_q, r_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          perr_q, perr_d;
  logic          wd_q, wd_d;        // winner withdrew its request early
  logic [IW-1:0] ptr_next;

  logic          arb_valid;
  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_idx;

  rr_arbiter #(.N(N)) u_rr (
    .req  (req),
    .ptr  (ptr_q),
    .valid(arb_valid),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign re_s     = re_sync_q[SYNC_STAGES-1];
  assign re_ok    = re_s & re_vld_q[SYNC_STAGES-1];
  assign re_rise  = re_s & ~re_prev_q;
  assign ptr_next = (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    re_sync_d = (re_sync_q << 1) | SYNC_STAGES'(Re);
    re_vld_d  = (re_vld_q << 1) | SYNC_STAGES'(1'b1);
    re_prev_d = re_s;

    state_d   = state_q;
    r_d       = r_q;
    ack_d     = ack_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    perr_d    = perr_q;
    wd_d      = wd_q;
    arb_valid = 1'b0;

    case (state_q)
      IDLE: begin
        arb_valid = re_ok;
        if (re_ok && (|req)) begin
          r_d     = e1of2_enc(|(din & arb_gnt));
          gid_d   = arb_idx;
          wd_d    = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!req[gid_q]) begin
          perr_d = 1'b1;
          wd_d   = 1'b1;
        end
        if (re_rise) begin
          perr_d = 1'b1;
        end else if (!re_s) begin
          r_d     = E1OF2_NULL;
          state_d = NULL;
        end
      end
      NULL: begin
        if (!req[gid_q]) begin
          perr_d = 1'b1;
          wd_d   = 1'b1;
        end
        if (re_s) begin
          // A withdrawn requester is never acknowledged; the channel cycle still completes.
          if (wd_q || !req[gid_q]) begin
            ptr_d   = ptr_next;
            state_d = IDLE;
          end else begin
            ack_d   = N'(1) << gid_q;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (!req[gid_q]) begin
          ack_d   = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: RESET is asynchronous and active-high, so it sits in the sensitivity list and aborts any transaction at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      re_sync_q <= '1;
      re_vld_q  <= '0;
      re_prev_q <= 1'b1;
      state_q   <= IDLE;
      r_q       <= E1OF2_NULL;
      ack_q     <= '0;
      gid_q     <= '0;
      ptr_q     <= '0;
      perr_q    <= 1'b0;
      wd_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      re_sync_q <= re_sync_d;
      re_vld_q  <= re_vld_d;
      re_prev_q <= re_prev_d;
      state_q   <= state_d;
      r_q       <= r_d;
      ack_q     <= ack_d;
      gid_q     <= gid_d;
      ptr_q     <= ptr_d;
      perr_q    <= perr_d;
      wd_q      <= wd_d;
    end
  end

  assign R         = r_q;
  assign ack       = ack_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = perr_q;

endmodule
